// File: rtl/mrd_rdx2345_sched.sv
// Pass sequencer for the mixed-radix (2/3/4/5) butterfly datapath: validates the
// factor list, then issues one butterfly read descriptor per cycle for each pass.
module mrd_rdx2345_sched #(
    parameter int N_MAX     = 1200,
    parameter int DRAIN_CYC = 28,
    parameter int ADDR_LAT  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [10:0]     cfg_n,
    input  logic [2:0]      cfg_nstage,
    input  logic [0:4][2:0] cfg_factor,
    input  logic            hold,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [2:0]      stage,
    output logic            rd_valid,
    output logic [2:0]      factor,
    output logic [10:0]     twdl_numrtr,
    output logic [10:0]     twdl_demontr,
    output logic [0:4][2:0] bank_index,
    output logic [0:4][7:0] bank_addr,
    output logic [2:0]      dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_PREP, S_ISSUE, S_DRAIN, S_FIN
    } state_t;

    localparam int DW = 1 + 11 + 11 + 15 + 40;
    localparam int DCW = $clog2(DRAIN_CYC + 1);
    localparam logic [10:0] N_MAX_W = 11'(N_MAX);
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYC - 2);

    state_t state_q, state_d;
    logic [10:0] n_q, n_d;
    logic [2:0] nstage_q, nstage_d;
    logic [0:4][2:0] fac_q, fac_d;
    logic [2:0] stage_q, stage_d, factor_q, factor_d;
    logic [10:0] stride_q, stride_d, lmul_q, lmul_d;
    logic [10:0] j_q, j_d, gbase_q, gbase_d, elem_q, elem_d;
    logic [DCW-1:0] drain_q, drain_d;
    logic busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [ADDR_LAT-1:0][DW-1:0] pipe_q, pipe_d;

    logic [15:0] prod_c, lm_c, st_c;
    logic bad_fac_c, reject_c, issue_c;
    logic [2:0] nxt_stage_c, nxt_fac_c;
    logic [10:0] numrtr_c, demontr_c, elem_nxt_c;
    logic [10:0] lane_n_c [5];
    logic [0:4][2:0] lane_idx_c;
    logic [0:4][7:0] lane_addr_c;
    logic [DW-1:0] head_c;

    // Configuration products and lane address arithmetic.
    always_comb begin
        prod_c = 16'd1;
        lm_c = 16'd1;
        st_c = 16'd1;
        bad_fac_c = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (3'(i) < nstage_q) begin
                prod_c = 16'(prod_c * 16'(fac_q[i]));
                if (fac_q[i] < 3'd2 || fac_q[i] > 3'd5) bad_fac_c = 1'b1;
                if (3'(i) < stage_q) lm_c = 16'(lm_c * 16'(fac_q[i]));
                else if (3'(i) > stage_q) st_c = 16'(st_c * 16'(fac_q[i]));
            end
        end
        reject_c = (nstage_q == 3'd0) || (nstage_q > 3'd5) || bad_fac_c ||
                   (n_q > N_MAX_W) || (prod_c != 16'(n_q));
        nxt_stage_c = stage_q + 3'd1;
        nxt_fac_c = 3'd0;
        for (int i = 0; i < 5; i++) begin
            if (3'(i) == nxt_stage_c) nxt_fac_c = fac_q[i];
        end
        numrtr_c = 11'(j_q * lmul_q);
        demontr_c = 11'(stride_q * 11'(factor_q));
        elem_nxt_c = elem_q + 11'(factor_q);
        // Divide by 5 as multiply by 13108 and shift by 16: exact for n < 1200.
        for (int m = 0; m < 5; m++) begin
            lane_n_c[m] = gbase_q + j_q + 11'(m) * stride_q;
            lane_addr_c[m] = 8'd0;
            lane_idx_c[m] = 3'd0;
            if (3'(m) < factor_q) begin
                lane_addr_c[m] = 8'((24'(lane_n_c[m]) * 24'd13108) >> 16);
                lane_idx_c[m] = 3'(lane_n_c[m] - 11'(lane_addr_c[m]) * 11'd5);
            end
        end
    end

    // Next-state logic for the pass sequencer.
    always_comb begin
        state_d = state_q;
        n_d = n_q;
        nstage_d = nstage_q;
        fac_d = fac_q;
        stage_d = stage_q;
        factor_d = factor_q;
        stride_d = stride_q;
        lmul_d = lmul_q;
        j_d = j_q;
        gbase_d = gbase_q;
        elem_d = elem_q;
        drain_d = drain_q;
        err_d = 1'b0;
        issue_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_d = cfg_n;
                    nstage_d = cfg_nstage;
                    fac_d = cfg_factor;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (reject_c) begin
                    err_d = 1'b1;
                    state_d = S_FIN;
                end else begin
                    stage_d = 3'd0;
                    factor_d = fac_q[0];
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                stride_d = 11'(st_c);
                lmul_d = 11'(lm_c);
                j_d = 11'd0;
                gbase_d = 11'd0;
                elem_d = 11'd0;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (!hold) begin
                    issue_c = 1'b1;
                    if (j_q + 11'd1 == stride_q) begin
                        j_d = 11'd0;
                        gbase_d = gbase_q + demontr_c;
                    end else begin
                        j_d = j_q + 11'd1;
                    end
                    elem_d = elem_nxt_c;
                    if (elem_nxt_c == n_q) begin
                        drain_d = '0;
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // PREP supplies the last idle cycle before the next pass issues.
                if (drain_q == DRAIN_LAST) begin
                    if (nxt_stage_c == nstage_q) begin
                        state_d = S_FIN;
                    end else begin
                        stage_d = nxt_stage_c;
                        factor_d = nxt_fac_c;
                        state_d = S_PREP;
                    end
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            S_FIN: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE) && (state_d != S_FIN);
        done_d = (state_d == S_FIN);
        head_c = issue_c ? {1'b1, numrtr_c, demontr_c, lane_idx_c, lane_addr_c} : '0;
        pipe_d = '0;
        pipe_d[0] = head_c;
        for (int i = 1; i < ADDR_LAT; i++) pipe_d[i] = pipe_q[i-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            n_q <= '0;
            nstage_q <= '0;
            fac_q <= '0;
            stage_q <= '0;
            factor_q <= '0;
            stride_q <= '0;
            lmul_q <= '0;
            j_q <= '0;
            gbase_q <= '0;
            elem_q <= '0;
            drain_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q <= 1'b0;
            pipe_q <= '0;
        end else begin
            state_q <= state_d;
            n_q <= n_d;
            nstage_q <= nstage_d;
            fac_q <= fac_d;
            stage_q <= stage_d;
            factor_q <= factor_d;
            stride_q <= stride_d;
            lmul_q <= lmul_d;
            j_q <= j_d;
            gbase_q <= gbase_d;
            elem_q <= elem_d;
            drain_q <= drain_d;
            busy_q <= busy_d;
            done_q <= done_d;
            err_q <= err_d;
            pipe_q <= pipe_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign err = err_q;
    assign stage = stage_q;
    assign factor = factor_q;
    assign dbg_state = state_q;
    assign {rd_valid, twdl_numrtr, twdl_demontr, bank_index, bank_addr} = pipe_q[ADDR_LAT-1];

endmodule

// File: tb/tb_mrd_rdx2345_sched.sv
// Bench for mrd_rdx2345_sched: directed and random factor lists checked against
// an arithmetic descriptor model through an expected queue.
module tb_mrd_rdx2345_sched;
    localparam int DRAIN_CYC = 28;
    localparam int W = 83;

    logic clk = 1'b0;
    logic rst, start, hold;
    logic [10:0] cfg_n;
    logic [2:0] cfg_nstage;
    logic [0:4][2:0] cfg_factor;
    logic busy, done, err, rd_valid;
    logic [2:0] stage, factor, dbg_state;
    logic [10:0] twdl_numrtr, twdl_demontr;
    logic [0:4][2:0] bank_index;
    logic [0:4][7:0] bank_addr;

    mrd_rdx2345_sched dut (
        .clk(clk), .rst(rst), .start(start), .cfg_n(cfg_n), .cfg_nstage(cfg_nstage),
        .cfg_factor(cfg_factor), .hold(hold), .busy(busy), .done(done), .err(err),
        .stage(stage), .rd_valid(rd_valid), .factor(factor), .twdl_numrtr(twdl_numrtr),
        .twdl_demontr(twdl_demontr), .bank_index(bank_index), .bank_addr(bank_addr),
        .dbg_state(dbg_state)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];
    int pass_cnt[5];
    int gap_q[$];
    int total_valid = 0;
    int done_cnt = 0;
    int last_valid_cyc = -1;
    int max_addr = 0;
    bit first_seen = 1'b0;
    logic [W-1:0] first_desc;
    int fa[5];

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [W-1:0] dut_desc();
        return {factor, stage, twdl_numrtr, twdl_demontr, bank_index, bank_addr};
    endfunction

    function automatic bit cfg_ok(input int n, input int ns, input int f[5]);
        int p;
        if (ns < 1 || ns > 5) return 1'b0;
        p = 1;
        for (int i = 0; i < ns; i++) begin
            if (f[i] < 2 || f[i] > 5) return 1'b0;
            p *= f[i];
        end
        if (n > 1200) return 1'b0;
        return p == n;
    endfunction

    // Reference: butterfly b of pass s covers group b/stride, offset b%stride.
    task automatic model_push(input int n, input int ns, input int f[5]);
        int ff, lm, st, j, g, base, nn;
        logic [0:4][2:0] bi;
        logic [0:4][7:0] ba;
        for (int s = 0; s < ns; s++) begin
            ff = f[s];
            lm = 1;
            st = 1;
            for (int i = 0; i < s; i++) lm *= f[i];
            for (int i = s + 1; i < ns; i++) st *= f[i];
            for (int b = 0; b < n / ff; b++) begin
                j = b % st;
                g = b / st;
                base = g * st * ff + j;
                bi = '0;
                ba = '0;
                for (int m = 0; m < ff; m++) begin
                    nn = base + m * st;
                    bi[m] = 3'(nn % 5);
                    ba[m] = 8'(nn / 5);
                end
                exp_q.push_back({3'(ff), 3'(s), 11'(j * lm), 11'(st * ff), bi, ba});
            end
        end
    endtask

    // scoreboard monitor
    initial begin
        forever begin
            @(negedge clk);
            if (rd_valid) begin
                total_valid++;
                if (stage < 3'd5) pass_cnt[stage]++;
                if (last_valid_cyc >= 0 && cyc != last_valid_cyc + 1) gap_q.push_back(cyc - last_valid_cyc);
                last_valid_cyc = cyc;
                if (!first_seen) begin
                    first_desc = dut_desc();
                    first_seen = 1'b1;
                end
                for (int m = 0; m < 5; m++) if (int'(bank_addr[m]) > max_addr) max_addr = int'(bank_addr[m]);
                chk("rd_valid_expected", W'(exp_q.size() != 0), W'(1));
                if (exp_q.size() != 0) chk("descriptor", dut_desc(), exp_q.pop_front());
            end
            if (done) done_cnt++;
        end
    end

    task automatic run_cfg(input int n, input int ns, input int f[5], input int hold_at,
                           input int hold_len, input bit rand_hold, input bit start_busy,
                           input bit start_fin, output int dur);
        bit ok;
        int t0, k, total0, done0, sum;
        ok = cfg_ok(n, ns, f);
        sum = 0;
        if (ok) begin
            model_push(n, ns, f);
            for (int s = 0; s < ns; s++) sum += n / f[s];
        end
        for (int s = 0; s < 5; s++) pass_cnt[s] = 0;
        gap_q.delete();
        last_valid_cyc = -1;
        first_seen = 1'b0;
        max_addr = 0;
        total0 = total_valid;
        done0 = done_cnt;
        @(negedge clk);
        cfg_n = 11'(n);
        cfg_nstage = 3'(ns);
        for (int i = 0; i < 5; i++) cfg_factor[i] = 3'(f[i]);
        start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", W'(busy), W'(1));
        k = cyc - t0;
        while (!done && k < 5000) begin
            if (rand_hold) hold = ($urandom_range(0, 3) == 0);
            else hold = (k >= hold_at && k < hold_at + hold_len);
            start = start_busy && (k == 10);
            if (start) cfg_n = 11'd5;
            @(negedge clk);
            k = cyc - t0;
        end
        hold = 1'b0;
        start = 1'b0;
        dur = cyc - t0;
        chk("done_seen", W'(done), W'(1));
        chk("err_with_done", W'(err), W'(!ok));
        chk("busy_low_at_done", W'(busy), W'(0));
        if (start_fin) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            @(negedge clk);
            chk("start_in_fin_ignored", W'(busy), W'(0));
        end
        repeat (3) @(negedge clk);
        chk("single_done", W'(done_cnt - done0), W'(1));
        chk("exp_q_drained", W'(exp_q.size()), W'(0));
        chk("valid_total", W'(total_valid - total0), W'(sum));
        if (ok) begin
            for (int s = 0; s < ns; s++) chk("pass_count", W'(pass_cnt[s]), W'(n / f[s]));
        end else begin
            chk("reject_latency", W'(dur), W'(2));
        end
        if (ok && !rand_hold && hold_len == 0) begin
            chk("gap_count", W'(gap_q.size()), W'(ns - 1));
            foreach (gap_q[i]) chk("drain_gap", W'(gap_q[i]), W'(DRAIN_CYC + 1));
        end
    endtask

    initial begin
        int d0, d1, k, p, ns;
        logic [0:4][2:0] bi;
        logic [0:4][7:0] ba;
        rst = 1'b1;
        start = 1'b0;
        hold = 1'b0;
        cfg_n = '0;
        cfg_nstage = '0;
        cfg_factor = '0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", W'({busy, done, err, stage, rd_valid, factor, twdl_numrtr,
            twdl_demontr, bank_index, bank_addr}), W'(0));
        chk("reset_state", W'(dbg_state), W'(0));
        rst = 1'b0;

        // N=12 {3,4} with start while busy and start in the done cycle
        fa = '{3, 4, 0, 0, 0};
        run_cfg(12, 2, fa, 0, 0, 1'b0, 1'b1, 1'b1, d0);
        bi = {3'd0, 3'd4, 3'd3, 3'd0, 3'd0};
        ba = {8'd0, 8'd0, 8'd1, 8'd0, 8'd0};
        chk("first_desc_n12", first_desc, {3'd3, 3'd0, 11'd0, 11'd12, bi, ba});

        fa = '{4, 5, 5, 3, 4};
        run_cfg(1200, 5, fa, 0, 0, 1'b0, 1'b0, 1'b0, d0);
        chk("max_bank_addr", W'(max_addr), W'(239));

        fa = '{3, 5, 0, 0, 0};
        run_cfg(12, 2, fa, 0, 0, 1'b0, 1'b0, 1'b0, d0);
        fa = '{5, 5, 5, 5, 2};
        run_cfg(1250, 5, fa, 0, 0, 1'b0, 1'b0, 1'b0, d0);
        fa = '{2, 2, 2, 0, 0};
        run_cfg(8, 0, fa, 0, 0, 1'b0, 1'b0, 1'b0, d0);
        run_cfg(8, 6, fa, 0, 0, 1'b0, 1'b0, 1'b0, d0);
        fa = '{2, 1, 4, 0, 0};
        run_cfg(8, 3, fa, 0, 0, 1'b0, 1'b0, 1'b0, d0);

        // hold for 5 cycles shifts completion by exactly 5 cycles
        fa = '{5, 4, 3, 0, 0};
        run_cfg(60, 3, fa, 0, 0, 1'b0, 1'b0, 1'b0, d0);
        run_cfg(60, 3, fa, 5, 5, 1'b0, 1'b0, 1'b0, d1);
        chk("hold_shift", W'(d1 - d0), W'(5));

        // reset during pass 1 aborts, then a clean rerun
        model_push(60, 3, fa);
        @(negedge clk);
        cfg_n = 11'd60;
        cfg_nstage = 3'd3;
        for (int i = 0; i < 5; i++) cfg_factor[i] = 3'(fa[i]);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!(stage == 3'd1 && rd_valid) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("reached_pass1", W'(stage == 3'd1 && rd_valid), W'(1));
        rst = 1'b1;
        @(negedge clk);
        chk("abort_rd_valid", W'(rd_valid), W'(0));
        chk("abort_busy", W'(busy), W'(0));
        rst = 1'b0;
        exp_q.delete();
        d0 = done_cnt;
        repeat (40) @(negedge clk);
        chk("abort_no_done", W'(done_cnt - d0), W'(0));
        run_cfg(60, 3, fa, 0, 0, 1'b0, 1'b0, 1'b0, d0);

        // random factor lists, some corrupted, half with random hold
        for (int r = 0; r < 8; r++) begin
            ns = $urandom_range(1, 5);
            p = 1;
            for (int i = 0; i < 5; i++) begin
                fa[i] = (i < ns) ? $urandom_range(2, 5) : $urandom_range(0, 7);
                if (i < ns) p *= fa[i];
            end
            if ($urandom_range(0, 3) == 0) fa[$urandom_range(0, ns - 1)] = $urandom_range(0, 7);
            if ($urandom_range(0, 4) == 0) p = p + 1;
            if (p > 2047) p = 2047;
            run_cfg(p, ns, fa, 0, 0, r[0], 1'b0, 1'b0, d0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
